// File: rtl/fifo_stream_adapter.sv
// FWFT FIFO read-port adapter: 2-entry skid buffer feeding a valid/ready stream framed into PKT_LEN-beat packets.
// Define FIFO_STREAM_STATS_EN to add the beat_count / pkt_count statistics ports.
module fifo_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FIFO_STREAM_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  pkt_count
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    occ_t                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [15:0]           beat_q, beat_d;
    logic                  push;
    logic                  accept;

    // The pop strobe looks only at registered occupancy, never at m_ready.
    assign fifo_rd_en = !rst && !fifo_empty && (occ_q != OCC_FULL);
    assign push       = fifo_rd_en;
    assign m_valid    = (occ_q != OCC_EMPTY);
    assign m_data     = head_q;
    assign m_last     = m_valid && (beat_q == LAST_BEAT);
    assign accept     = m_valid && m_ready;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        beat_d = beat_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = fifo_rd_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && accept) begin
                    head_d = fifo_rd_data;
                end else if (push) begin
                    tail_d = fifo_rd_data;
                    occ_d  = OCC_FULL;
                end else if (accept) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (accept) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        if (accept) begin
            beat_d = (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
            beat_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            beat_q <= beat_d;
        end
    end

`ifdef FIFO_STREAM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else begin
            if (accept) begin
                beat_count <= beat_count + CNT_WIDTH'(1);
            end
            if (accept && m_last) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_stats;
    assign unused_stats = '0;
`endif

endmodule
